// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: bundles the requester handshake and the uart_tx side
// of uart_tx_arbiter into one port.
// The master modport is the environment side: producers and the transmitter.
// The slave modport is the arbiter itself.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = 8
);
  localparam int ID_BITS = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]              i_req_valid;
  logic [NUM_REQ*PAYLOAD_BITS-1:0] i_req_data;
  logic [NUM_REQ-1:0]              o_req_ready;
  logic [ID_BITS-1:0]              o_grant_id;
  logic                            o_uart_tx_en;
  logic [PAYLOAD_BITS-1:0]         o_uart_tx_data;
  logic                            i_uart_tx_busy;
  logic                            o_busy;
  logic                            o_timeout_err;

  modport master (
    output i_req_valid, i_req_data, i_uart_tx_busy,
    input  o_req_ready, o_grant_id, o_uart_tx_en, o_uart_tx_data,
           o_busy, o_timeout_err
  );

  modport slave (
    input  i_req_valid, i_req_data, i_uart_tx_busy,
    output o_req_ready, o_grant_id, o_uart_tx_en, o_uart_tx_data,
           o_busy, o_timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between NUM_REQ byte producers using
// round-robin arbitration.
// A byte is accepted over valid/ready and sent with a one-cycle enable pulse.
// The arbiter follows the transmitter busy flag through the whole frame.
// A watchdog raises a sticky error if busy never rises after an enable.
// Optional macro UART_ARB_TAG_EN sends a tag frame {1, winner index} ahead of
// each payload byte.
// Reset is synchronous and active-low.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = 8,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  uart_tx_arbiter_if.slave  bus
);
  localparam int ID_BITS  = $clog2(NUM_REQ);
  localparam int CNT_BITS = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ARB,
    ISSUE,
    WAIT_RISE,
    WAIT_FALL
`ifdef UART_ARB_TAG_EN
    ,
    TAG_ISSUE,
    TAG_RISE,
    TAG_FALL
`endif
  } state_t;

  state_t                  state, state_next;
  logic [ID_BITS-1:0]      ptr, ptr_next;
  logic [CNT_BITS-1:0]     wd_cnt, wd_cnt_next;
  logic [PAYLOAD_BITS-1:0] tx_data, tx_data_next;
  logic [ID_BITS-1:0]      grant, grant_next;
  logic                    tx_en, tx_en_next;
  logic [NUM_REQ-1:0]      ready, ready_next;
  logic                    busy, busy_next;
  logic                    err, err_next;

  logic                    win_found;
  logic [ID_BITS-1:0]      win_idx;
  logic [ID_BITS-1:0]      cand;
  logic [PAYLOAD_BITS-1:0] win_data;
  logic                    wd_expired;

`ifdef UART_ARB_TAG_EN
  logic [PAYLOAD_BITS-1:0] hold, hold_next;
  logic [PAYLOAD_BITS-1:0] tag_byte;
`endif

  assign wd_expired = (wd_cnt == CNT_BITS'(BUSY_TIMEOUT - 1));

  // Round-robin search: first valid requester after the last winner, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_BITS'((int'(ptr) + i) % NUM_REQ);
      if (!win_found && bus.i_req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Select the winning requester's byte from the flattened data bus
  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == ID_BITS'(k)) begin
        win_data = bus.i_req_data[k*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

`ifdef UART_ARB_TAG_EN
  // Tag frame byte: MSB set, winner index in the low bits, zeros between
  always_comb begin
    tag_byte                   = '0;
    tag_byte[ID_BITS-1:0]      = win_idx;
    tag_byte[PAYLOAD_BITS-1]   = 1'b1;
  end
`endif

  // Next-state and next-output logic for the arbitration FSM
  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    wd_cnt_next  = '0;
    tx_data_next = tx_data;
    grant_next   = grant;
    tx_en_next   = 1'b0;
    ready_next   = '0;
    err_next     = err;
`ifdef UART_ARB_TAG_EN
    hold_next    = hold;
`endif

    case (state)
      ARB: begin
        if (win_found && !bus.i_uart_tx_busy) begin
          ptr_next   = win_idx;
          grant_next = win_idx;
          tx_en_next = 1'b1;
`ifdef UART_ARB_TAG_EN
          hold_next    = win_data;
          tx_data_next = tag_byte;
          state_next   = TAG_ISSUE;
`else
          tx_data_next        = win_data;
          ready_next[win_idx] = 1'b1;
          state_next          = ISSUE;
`endif
        end
      end

      ISSUE: begin
        state_next = WAIT_RISE;
      end

      WAIT_RISE: begin
        if (bus.i_uart_tx_busy) begin
          state_next = WAIT_FALL;
        end else if (wd_expired) begin
          err_next   = 1'b1;
          state_next = ARB;
        end else begin
          wd_cnt_next = wd_cnt + CNT_BITS'(1);
        end
      end

      WAIT_FALL: begin
        if (!bus.i_uart_tx_busy) begin
          state_next = ARB;
        end
      end

`ifdef UART_ARB_TAG_EN
      TAG_ISSUE: begin
        state_next = TAG_RISE;
      end

      TAG_RISE: begin
        if (bus.i_uart_tx_busy) begin
          state_next = TAG_FALL;
        end else if (wd_expired) begin
          err_next   = 1'b1;
          state_next = ARB;
        end else begin
          wd_cnt_next = wd_cnt + CNT_BITS'(1);
        end
      end

      TAG_FALL: begin
        if (!bus.i_uart_tx_busy) begin
          tx_data_next      = hold;
          tx_en_next        = 1'b1;
          ready_next[grant] = 1'b1;
          state_next        = ISSUE;
        end
      end
`endif

      default: begin
        state_next = ARB;
      end
    endcase

    busy_next = (state_next != ARB);
  end

  // State register; reset drops the FSM straight back to ARB
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state <= ARB;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and output registers so every output comes straight from a flop
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      ptr     <= ID_BITS'(NUM_REQ - 1);
      wd_cnt  <= '0;
      tx_data <= '0;
      grant   <= '0;
      tx_en   <= 1'b0;
      ready   <= '0;
      busy    <= 1'b0;
      err     <= 1'b0;
`ifdef UART_ARB_TAG_EN
      hold    <= '0;
`endif
    end else begin
      ptr     <= ptr_next;
      wd_cnt  <= wd_cnt_next;
      tx_data <= tx_data_next;
      grant   <= grant_next;
      tx_en   <= tx_en_next;
      ready   <= ready_next;
      busy    <= busy_next;
      err     <= err_next;
`ifdef UART_ARB_TAG_EN
      hold    <= hold_next;
`endif
    end
  end

  assign bus.o_req_ready    = ready;
  assign bus.o_grant_id     = grant;
  assign bus.o_uart_tx_en   = tx_en;
  assign bus.o_uart_tx_data = tx_data;
  assign bus.o_busy         = busy;
  assign bus.o_timeout_err  = err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with a small
// uart_tx behavioural model that holds busy for FRAME_CYCLES after an enable.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ      = 4;
  localparam int PAYLOAD_BITS = 8;
  localparam int BUSY_TIMEOUT = 15;
  localparam int FRAME_CYCLES = 5;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic model_on = 1'b1;
  logic force_busy = 1'b0;
  logic model_busy;
  int   model_cnt;

  logic [7:0] en_data_q[$];
  logic [1:0] en_grant_q[$];
  logic [3:0] en_ready_q[$];

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .PAYLOAD_BITS(PAYLOAD_BITS)) bus();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .PAYLOAD_BITS(PAYLOAD_BITS),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .i_clk(clk),
    .i_resetn(resetn),
    .bus(bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  assign bus.i_uart_tx_busy = model_busy | force_busy;

  // uart_tx model: busy rises the cycle after an enable and lasts FRAME_CYCLES
  always @(posedge clk) begin
    if (!resetn) begin
      model_busy <= 1'b0;
      model_cnt  <= 0;
    end else if (model_busy) begin
      if (model_cnt == 1) model_busy <= 1'b0;
      model_cnt <= model_cnt - 1;
    end else if (model_on && bus.o_uart_tx_en) begin
      model_busy <= 1'b1;
      model_cnt  <= FRAME_CYCLES;
    end
  end

  // Log every enable pulse with its byte, grant and ready vector
  always @(negedge clk) begin
    if (resetn && bus.o_uart_tx_en) begin
      en_data_q.push_back(bus.o_uart_tx_data);
      en_grant_q.push_back(bus.o_grant_id);
      en_ready_q.push_back(bus.o_req_ready);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input int idx,
                               input logic [7:0] data);
    bus.i_req_valid = valid;
    bus.i_req_data[idx*8 +: 8] = data;
  endtask

  task automatic doReset;
    resetn = 1'b0;
    bus.i_req_valid = '0;
    bus.i_req_data  = '0;
    force_busy = 1'b0;
    tick(3);
    en_data_q.delete();
    en_grant_q.delete();
    en_ready_q.delete();
    resetn = 1'b1;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while ((bus.o_busy || bus.i_uart_tx_busy) && n < 100) begin
      tick();
      n++;
    end
    checkOutput(tag, bus.o_busy, 0);
  endtask

  // Directed test sequence
  initial begin
    int n;
    int en_cnt;
    int busy_cnt;
    bus.i_req_valid = '0;
    bus.i_req_data  = '0;
    tick();
    doReset();

    checkOutput("rst_ready", bus.o_req_ready, 0);
    checkOutput("rst_en", bus.o_uart_tx_en, 0);
    checkOutput("rst_data", bus.o_uart_tx_data, 0);
    checkOutput("rst_grant", bus.o_grant_id, 0);
    checkOutput("rst_busy", bus.o_busy, 0);
    checkOutput("rst_err", bus.o_timeout_err, 0);

    en_cnt = 0;
    busy_cnt = 0;
    repeat (20) begin
      tick();
      if (bus.o_uart_tx_en) en_cnt++;
      if (bus.o_busy) busy_cnt++;
    end
    checkOutput("idle_en", en_cnt, 0);
    checkOutput("idle_busy", busy_cnt, 0);

`ifdef UART_ARB_TAG_EN
    applyStimulus(4'b1000, 3, 8'h3C);
    n = 0;
    while (en_data_q.size() < 2 && n < 100) begin
      tick();
      n++;
      if (bus.o_req_ready[3]) bus.i_req_valid = '0;
    end
    checkOutput("tag_count", en_data_q.size(), 2);
    if (en_data_q.size() >= 2) begin
      checkOutput("tag_byte", en_data_q[0], 8'h83);
      checkOutput("tag_ready", en_ready_q[0], 4'b0000);
      checkOutput("tag_payload", en_data_q[1], 8'h3C);
      checkOutput("tag_payload_ready", en_ready_q[1], 4'b1000);
      checkOutput("tag_grant", en_grant_q[1], 3);
    end
    waitIdle("tag_idle");
`else
    applyStimulus(4'b0100, 2, 8'hA5);
    tick();
    checkOutput("single_en", bus.o_uart_tx_en, 1);
    checkOutput("single_ready", bus.o_req_ready, 4'b0100);
    checkOutput("single_data", bus.o_uart_tx_data, 8'hA5);
    checkOutput("single_grant", bus.o_grant_id, 2);
    applyStimulus(4'b0100, 2, 8'h5A);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.o_uart_tx_en && n < 50);
    checkOutput("single_regrant_delay", n, 8);
    checkOutput("single_regrant_data", bus.o_uart_tx_data, 8'h5A);
    bus.i_req_valid = '0;
    waitIdle("single_idle");

    doReset();
    applyStimulus(4'b1011, 0, 8'h10);
    applyStimulus(4'b1011, 1, 8'h11);
    applyStimulus(4'b1011, 3, 8'h13);
    n = 0;
    while (en_grant_q.size() < 6 && n < 300) begin
      tick();
      n++;
    end
    bus.i_req_valid = '0;
    checkOutput("rr_count", en_grant_q.size(), 6);
    begin
      logic [1:0] exp_g [6];
      logic [7:0] exp_d [6];
      exp_g = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
      exp_d = '{8'h10, 8'h11, 8'h13, 8'h10, 8'h11, 8'h13};
      for (int i = 0; i < 6 && i < en_grant_q.size(); i++) begin
        checkOutput($sformatf("rr_grant%0d", i), en_grant_q[i], exp_g[i]);
        checkOutput($sformatf("rr_ready%0d", i), en_ready_q[i], 4'b0001 << exp_g[i]);
        checkOutput($sformatf("rr_data%0d", i), en_data_q[i], exp_d[i]);
      end
    end
    waitIdle("rr_idle");

    force_busy = 1'b1;
    applyStimulus(4'b0010, 1, 8'h77);
    en_cnt = 0;
    repeat (5) begin
      tick();
      if (bus.o_uart_tx_en) en_cnt++;
    end
    checkOutput("prebusy_hold", en_cnt, 0);
    force_busy = 1'b0;
    tick();
    checkOutput("prebusy_en", bus.o_uart_tx_en, 1);
    checkOutput("prebusy_grant", bus.o_grant_id, 1);
    checkOutput("prebusy_ready", bus.o_req_ready, 4'b0010);
    checkOutput("prebusy_data", bus.o_uart_tx_data, 8'h77);
    bus.i_req_valid = '0;
    waitIdle("prebusy_idle");

    model_on = 1'b0;
    applyStimulus(4'b0001, 0, 8'h42);
    tick();
    checkOutput("wd_en", bus.o_uart_tx_en, 1);
    checkOutput("wd_grant", bus.o_grant_id, 0);
    bus.i_req_valid = '0;
    n = 0;
    while (!bus.o_timeout_err && n < 40) begin
      tick();
      n++;
    end
    checkOutput("wd_latency", n, BUSY_TIMEOUT + 1);
    checkOutput("wd_back_to_arb", bus.o_busy, 0);
    model_on = 1'b1;
    applyStimulus(4'b1000, 3, 8'h99);
    tick();
    checkOutput("wd_next_en", bus.o_uart_tx_en, 1);
    checkOutput("wd_next_grant", bus.o_grant_id, 3);
    checkOutput("wd_next_data", bus.o_uart_tx_data, 8'h99);
    checkOutput("wd_sticky", bus.o_timeout_err, 1);
    bus.i_req_valid = '0;
    waitIdle("wd_idle");
    doReset();
    checkOutput("wd_cleared", bus.o_timeout_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end
endmodule
